// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce/edge-detect block.
// The state enumeration is shared so other blocks can decode debounce state.
package debounce_pkg;

  localparam int DEFAULT_STABLE_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_LOW      = 2'b00,
    ST_CHK_HIGH = 2'b01,
    ST_HIGH     = 2'b10,
    ST_CHK_LOW  = 2'b11
  } state_e;

  // Debounced level implied by a state: HIGH and CHK_LOW both present dout=1.
  function automatic logic level_of(input state_e st);
    return (st == ST_HIGH) || (st == ST_CHK_LOW);
  endfunction

  function automatic logic is_checking(input state_e st);
    return (st == ST_CHK_HIGH) || (st == ST_CHK_LOW);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit.
// Both stages clear on the asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_async_n,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/debounce_edge.sv
// Debouncer with edge pulses: a new synchronized level is accepted only after
// STABLE_CYCLES consecutive ce-qualified samples, with one-cycle rise/fall pulses.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic rst_async_n,
  input  logic rst_sync,
  input  logic din,
  input  logic ce,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             dout_d, dout_q;
  logic             rise_d, rise_q;
  logic             fall_d, fall_q;
  logic             clr_d, clr_q;
  logic             sync_in;
  logic             s_raw;
  logic             s;

  // The synchronizer has no synchronous clear, so the first stage is fed 0 on a
  // clear and the stale second stage is masked for the following cycle; the FSM
  // therefore sees exactly what it would with both stages cleared.
  assign sync_in = din & ~rst_sync;

  sync_2ff u_sync (
    .clk         (clk),
    .rst_async_n (rst_async_n),
    .d           (sync_in),
    .q           (s_raw)
  );

  assign s = s_raw & ~clr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    clr_d   = rst_sync;
    if (rst_sync) begin
      state_d = ST_LOW;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_LOW: begin
          if (s) begin
            state_d = ST_CHK_HIGH;
            cnt_d   = '0;
          end
        end
        ST_CHK_HIGH: begin
          if (!s) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else if (ce) begin
            if (cnt_q == CNT_LAST) begin
              state_d = ST_HIGH;
              cnt_d   = '0;
              rise_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_HIGH: begin
          if (!s) begin
            state_d = ST_CHK_LOW;
            cnt_d   = '0;
          end
        end
        ST_CHK_LOW: begin
          if (s) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else if (ce) begin
            if (cnt_q == CNT_LAST) begin
              state_d = ST_LOW;
              cnt_d   = '0;
              fall_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end
      endcase
    end
    dout_d = level_of(state_d);
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      clr_q   <= clr_d;
    end
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = is_checking(state_q);

endmodule
